// File: rtl/plic_gw_pkg.sv
// Shared types and sizing helpers for the PLIC interrupt gateway.
package plic_gw_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    ACTIVE  = 2'b10
  } gw_state_e;

  // Width of a source ID; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturation value of a queued-edge counter of the given width.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/plic_gw_src.sv
// One interrupt source: synchroniser, edge detect, queued-edge counter,
// sticky overflow flag and the IDLE/PENDING/ACTIVE claim-complete FSM.
module plic_gw_src
  import plic_gw_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 4
) (
  input  logic pclk_i,
  input  logic prst_n_i,
  input  logic test_mode_i,
  input  logic irq,
  input  logic edge_mode,
  input  logic claim_hit,
  input  logic complete_hit,
  input  logic ovf_clr,
  output logic pending,
  output logic active,
  output logic edge_ovf
);

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = EDGE_CNT_W'(cnt_max(EDGE_CNT_W));

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   edge_det;
  logic                   consume;
  logic                   ovf_set;
  logic [EDGE_CNT_W-1:0]  cnt_q;
  logic [EDGE_CNT_W-1:0]  cnt_d;
  gw_state_e              state_q;
  gw_state_e              state_d;

  // Shift the raw request through the metastability chain.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) sync_q <= '0;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
  end

  assign s        = test_mode_i ? irq : sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~s_d;

  // Previous sample, queued-edge counter and sticky overflow flag.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      s_d      <= 1'b0;
      cnt_q    <= '0;
      edge_ovf <= 1'b0;
    end else begin
      s_d      <= s;
      cnt_q    <= cnt_d;
      edge_ovf <= ovf_set | (edge_ovf & ~ovf_clr);
    end
  end

  // State register.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state; consume marks an edge-mode entry into PENDING that uses up one queued or fresh edge.
  always_comb begin
    state_d = state_q;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_mode) begin
          if (edge_det || (cnt_q != '0)) begin
            state_d = PENDING;
            consume = 1'b1;
          end
        end else if (s) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (claim_hit)              state_d = ACTIVE;
        else if (!edge_mode && !s)  state_d = IDLE;
      end
      ACTIVE: begin
        if (complete_hit) begin
          if (edge_mode) begin
            if (edge_det || (cnt_q != '0)) begin
              state_d = PENDING;
              consume = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = s ? PENDING : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter update: net of the fresh edge and the consumed edge, saturating with overflow detect.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (!edge_mode) begin
      cnt_d = '0;
    end else if (edge_det && !consume) begin
      if (cnt_q == CNT_MAX) ovf_set = 1'b1;
      else                  cnt_d   = cnt_q + EDGE_CNT_W'(1);
    end else if (!edge_det && consume) begin
      cnt_d = cnt_q - EDGE_CNT_W'(1);
    end
  end

  // Status outputs decoded straight from the state flops.
  always_comb begin
    pending = (state_q == PENDING);
    active  = (state_q == ACTIVE);
  end

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: per-source request FSMs plus claim/complete decode
// with lowest-target-index priority when several targets claim the same ID.
module plic_gateway
  import plic_gw_pkg::*;
#(
  parameter int NUM_IRQ     = 64,
  parameter int NUM_TGT     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 4,
  parameter int ID_W        = id_width(NUM_IRQ)
) (
  input  logic                    pclk_i,
  input  logic                    prst_n_i,
  input  logic                    test_mode_i,
  input  logic [NUM_IRQ-1:0]      irq_i,
  input  logic [NUM_IRQ-1:0]      irq_edge_mode_i,
  input  logic [NUM_TGT-1:0]      claim_vld_i,
  input  logic [NUM_TGT*ID_W-1:0] claim_id_i,
  output logic [NUM_TGT-1:0]      claim_ack_o,
  input  logic [NUM_TGT-1:0]      complete_vld_i,
  input  logic [NUM_TGT*ID_W-1:0] complete_id_i,
  output logic [NUM_IRQ-1:0]      pending_o,
  output logic [NUM_IRQ-1:0]      active_o,
  output logic [NUM_IRQ-1:0]      edge_ovf_o,
  input  logic [NUM_IRQ-1:0]      ovf_clr_i
);

  logic [ID_W-1:0]    claim_id    [NUM_TGT];
  logic [ID_W-1:0]    complete_id [NUM_TGT];
  logic [NUM_IRQ-1:0] claim_hit;
  logic [NUM_IRQ-1:0] complete_hit;
  logic               unused_bits;

  // Unpack the per-target ID buses.
  always_comb begin
    for (int t = 0; t < NUM_TGT; t++) begin
      claim_id[t]    = claim_id_i[t*ID_W +: ID_W];
      complete_id[t] = complete_id_i[t*ID_W +: ID_W];
    end
  end

  // Accept a claim when its ID is pending and no lower-index target claims the same ID this cycle.
  always_comb begin
    logic sel_pend;
    logic shadowed;
    claim_ack_o = '0;
    sel_pend    = 1'b0;
    shadowed    = 1'b0;
    for (int t = 0; t < NUM_TGT; t++) begin
      sel_pend = 1'b0;
      shadowed = 1'b0;
      for (int i = 1; i < NUM_IRQ; i++) begin
        if ((claim_id[t] == ID_W'(i)) && pending_o[i]) sel_pend = 1'b1;
      end
      for (int u = 0; u < t; u++) begin
        if (claim_vld_i[u] && (claim_id[u] == claim_id[t])) shadowed = 1'b1;
      end
      claim_ack_o[t] = claim_vld_i[t] & sel_pend & ~shadowed;
    end
  end

  // Fold accepted claims and completes of active IDs into per-source strobes.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 1; i < NUM_IRQ; i++) begin
      for (int t = 0; t < NUM_TGT; t++) begin
        if (claim_ack_o[t] && (claim_id[t] == ID_W'(i))) claim_hit[i] = 1'b1;
        if (complete_vld_i[t] && (complete_id[t] == ID_W'(i)) && active_o[i]) complete_hit[i] = 1'b1;
      end
    end
  end

  for (genvar i = 1; i < NUM_IRQ; i++) begin : g_src
    plic_gw_src #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_CNT_W  (EDGE_CNT_W)
    ) u_src (
      .pclk_i       (pclk_i),
      .prst_n_i     (prst_n_i),
      .test_mode_i  (test_mode_i),
      .irq          (irq_i[i]),
      .edge_mode    (irq_edge_mode_i[i]),
      .claim_hit    (claim_hit[i]),
      .complete_hit (complete_hit[i]),
      .ovf_clr      (ovf_clr_i[i]),
      .pending      (pending_o[i]),
      .active       (active_o[i]),
      .edge_ovf     (edge_ovf_o[i])
    );
  end

  // ID 0 is reserved and never requests.
  assign pending_o[0]  = 1'b0;
  assign active_o[0]   = 1'b0;
  assign edge_ovf_o[0] = 1'b0;

  assign unused_bits = ^{irq_i[0], irq_edge_mode_i[0], ovf_clr_i[0], claim_hit[0], complete_hit[0]};

endmodule
